// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and feeder FSM states.
package uart_pkg;

   localparam int unsigned UART_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      SEND  = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and a sticky overflow flag.
// Read data is the current head; rd_en advances past it.
module uart_sync_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow
);

   localparam int unsigned LW = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [LW-1:0]         level_nxt;
   logic                  wr_acc;
   logic                  rd_acc;

   // A write while full is dropped even if a read frees a slot in the same cycle.
   assign wr_acc  = wr_en && !full;
   assign rd_acc  = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      level_nxt = level;
      case ({wr_acc, rd_acc})
         2'b10:   level_nxt = level + LW'(1);
         2'b01:   level_nxt = level - LW'(1);
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         level <= level_nxt;
         full  <= (level_nxt == LW'(DEPTH));
         empty <= (level_nxt == LW'(0));
         if (wr_en && full) overflow <= 1'b1;
      end
   end

   // Storage needs no reset; the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Feeds buffered host bytes to the UART transmitter one frame at a time,
// pacing on Tx_Active/Tx_Done.
module uart_tx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  internal_clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] Tx_Byte,
   output logic                  Tx_Enable,
   input  logic                  Tx_Active,
   input  logic                  Tx_Done
);

   localparam int unsigned LW = ADDR_WIDTH + 1;

   tx_state_e             state;
   logic [DATA_WIDTH-1:0] head;
   logic                  pop;
   logic                  wr_acc;
   logic                  will_be_empty;

   uart_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .clk      (internal_clock),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (head),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow)
   );

   // The Tx_Active guard keeps a frame that survived a reset from being overlapped.
   assign pop    = (state == IDLE) && !empty && !Tx_Active;
   assign wr_acc = wr_en && !full;

   // FIFO occupancy after this edge, so busy can be registered alongside the state.
   assign will_be_empty = !wr_acc && (empty || (pop && (level == LW'(1))));

   always_ff @(posedge internal_clock) begin
      if (reset) begin
         state     <= IDLE;
         Tx_Enable <= 1'b0;
         Tx_Byte   <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  Tx_Byte   <= head;
                  Tx_Enable <= 1'b1;
                  state     <= START;
                  busy      <= 1'b1;
               end else begin
                  Tx_Enable <= 1'b0;
                  busy      <= !will_be_empty;
               end
            end
            START: begin
               busy <= 1'b1;
               if (Tx_Active) begin
                  Tx_Enable <= 1'b0;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (Tx_Done) begin
                  state <= IDLE;
                  busy  <= !will_be_empty;
               end else begin
                  busy  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               Tx_Enable <= 1'b0;
               busy      <= !will_be_empty;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: directed vectors, corner sequences and random traffic
// checked against a queue-based transaction model and an in-order byte scoreboard.
module tb_uart_tx_fifo_ctrl;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic          overflow;
   logic          busy;
   logic [DW-1:0] tx_byte;
   logic          tx_enable;
   logic          tx_active;
   logic          tx_done;

   uart_tx_fifo_ctrl #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .internal_clock (clk),
      .reset          (reset),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .full           (full),
      .empty          (empty),
      .level          (level),
      .overflow       (overflow),
      .busy           (busy),
      .Tx_Byte        (tx_byte),
      .Tx_Enable      (tx_enable),
      .Tx_Active      (tx_active),
      .Tx_Done        (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   // Transaction model: FIFO contents, controller availability, outstanding request.
   logic [DW-1:0] q[$];
   logic [DW-1:0] sb[$];
   logic [DW-1:0] rx[$];
   bit            m_free;
   bit            m_req;
   bit            m_ovf;
   logic [DW-1:0] m_byte;

   bit auto_tx;
   int frame_cnt;

   typedef struct {
      bit          wr;
      logic [7:0]  d;
      bit          act;
      bit          done;
      bit          en;
      logic [7:0]  b;
      bit          emp;
      int unsigned lvl;
      bit          bsy;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 50)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int  n;
      bit  do_pop;
      bit  do_wr;
      if (reset) begin
         q.delete();
         sb.delete();
         m_free = 1'b1;
         m_req  = 1'b0;
         m_ovf  = 1'b0;
         m_byte = '0;
      end else begin
         n      = q.size();
         do_pop = m_free && (n > 0) && !tx_active;
         do_wr  = wr_en && (n < int'(DEPTH));
         if (wr_en && (n == int'(DEPTH))) m_ovf = 1'b1;
         if (do_pop) begin
            m_byte = q.pop_front();
            m_free = 1'b0;
            m_req  = 1'b1;
         end else if (m_req && tx_active) begin
            m_req = 1'b0;
         end else if (!m_free && !m_req && tx_done) begin
            m_free = 1'b1;
         end
         if (do_wr) begin
            q.push_back(wr_data);
            sb.push_back(wr_data);
         end
      end
   endtask

   task automatic check_model();
      chk("level",     32'(level),     32'(q.size()));
      chk("full",      32'(full),      32'(q.size() == int'(DEPTH)));
      chk("empty",     32'(empty),     32'(q.size() == 0));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("tx_enable", 32'(tx_enable), 32'(m_req));
      chk("tx_byte",   32'(tx_byte),   32'(m_byte));
      chk("busy",      32'(busy),      32'(!m_free || (q.size() > 0)));
   endtask

   // Transmitter model: accepts a request after a random delay, then runs a short frame.
   task automatic drive_tx();
      tx_done = 1'b0;
      if (tx_active) begin
         if (frame_cnt == 0) begin
            tx_active = 1'b0;
            tx_done   = 1'b1;
         end else begin
            frame_cnt--;
         end
      end else if (tx_enable && ($urandom_range(0, 2) != 0)) begin
         rx.push_back(tx_byte);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected: got byte 0x%0h with nothing outstanding at %0t", tx_byte, $time);
         end else begin
            chk("rx_order", 32'(tx_byte), 32'(sb.pop_front()));
         end
         tx_active = 1'b1;
         frame_cnt = $urandom_range(0, 4);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
      if (auto_tx) drive_tx();
   endtask

   task automatic drain();
      bit drained;
      drained = 1'b0;
      wr_en   = 1'b0;
      for (int n = 0; n < 2000 && !drained; n++) begin
         tick();
         if (q.size() == 0 && m_free && !tx_active && !tx_done) drained = 1'b1;
      end
      chk("drain_done", 32'(drained), 32'd1);
   endtask

   task automatic put(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      wr_en     = 1'b0;
      wr_data   = '0;
      tx_active = 1'b0;
      tx_done   = 1'b0;
      auto_tx   = 1'b0;
      frame_cnt = 0;
      m_free    = 1'b1;
      m_req     = 1'b0;
      m_ovf     = 1'b0;
      m_byte    = '0;

      tick();
      tick();
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_empty", 32'(empty),     32'd1);
         chk("idle_full",  32'(full),      32'd0);
         chk("idle_level", 32'(level),     32'd0);
         chk("idle_en",    32'(tx_enable), 32'd0);
         chk("idle_byte",  32'(tx_byte),   32'd0);
         chk("idle_busy",  32'(busy),      32'd0);
      end

      // Single byte 0xA5 through a full handshake
      tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1, 1'b1};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 0, 1'b1};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 0, 1'b1};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 0, 1'b1};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 0, 1'b1};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 0, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         wr_en     = tbl[i].wr;
         wr_data   = tbl[i].d;
         tx_active = tbl[i].act;
         tx_done   = tbl[i].done;
         tick();
         chk($sformatf("vec%0d_en", i),    32'(tx_enable), 32'(tbl[i].en));
         chk($sformatf("vec%0d_byte", i),  32'(tx_byte),   32'(tbl[i].b));
         chk($sformatf("vec%0d_empty", i), 32'(empty),     32'(tbl[i].emp));
         chk($sformatf("vec%0d_level", i), 32'(level),     tbl[i].lvl);
         chk($sformatf("vec%0d_busy", i),  32'(busy),      32'(tbl[i].bsy));
      end
      wr_en   = 1'b0;
      tx_done = 1'b0;
      sb.delete();

      // Burst of 16 into a stalled transmitter, then one overflowing write
      tx_active = 1'b1;
      for (int i = 0; i < 16; i++) put(8'(i));
      chk("burst_full",  32'(full),  32'd1);
      chk("burst_level", 32'(level), 32'd16);
      chk("burst_ovf0",  32'(overflow), 32'd0);
      put(8'hFF);
      chk("ovf_set",   32'(overflow), 32'd1);
      chk("ovf_level", 32'(level),    32'd16);
      tx_active = 1'b0;
      rx.delete();
      auto_tx = 1'b1;
      drain();
      chk("burst_rx_count", 32'(rx.size()), 32'd16);
      for (int i = 0; i < 16 && i < rx.size(); i++)
         chk($sformatf("burst_rx%0d", i), 32'(rx[i]), 32'(i));

      // Move the pointers near the top so the next group wraps
      for (int i = 0; i < 12; i++) put(8'h40 + 8'(i));
      drain();

      // Simultaneous write and pop at level 5
      auto_tx   = 1'b0;
      tx_active = 1'b1;
      for (int i = 0; i < 5; i++) put(8'h60 + 8'(i));
      chk("lvl5_before", 32'(level), 32'd5);
      tx_active = 1'b0;
      put(8'h65);
      chk("lvl5_wr_pop", 32'(level), 32'd5);
      chk("lvl5_en",     32'(tx_enable), 32'd1);
      rx.delete();
      auto_tx = 1'b1;
      drain();
      chk("wrap_rx_count", 32'(rx.size()), 32'd6);
      for (int i = 0; i < 6 && i < rx.size(); i++)
         chk($sformatf("wrap_rx%0d", i), 32'(rx[i]), 32'h60 + 32'(i));

      // Reset during SEND with three bytes queued
      auto_tx = 1'b0;
      put(8'h11);
      put(8'h22);
      put(8'h33);
      put(8'h44);
      tx_active = 1'b1;
      tick();
      tick();
      chk("rst_pre_level", 32'(level), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_level", 32'(level),     32'd0);
      chk("rst_en",    32'(tx_enable), 32'd0);
      chk("rst_empty", 32'(empty),     32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_hold_en", 32'(tx_enable), 32'd0);
      end
      tx_active = 1'b0;
      tx_done   = 1'b1;
      tick();
      tx_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_noreq_en", 32'(tx_enable), 32'd0);
      end
      put(8'h55);
      tick();
      chk("rst_fresh_en",   32'(tx_enable), 32'd1);
      chk("rst_fresh_byte", 32'(tx_byte),   32'h55);
      tx_active = 1'b1;
      tick();
      tx_active = 1'b0;
      tx_done   = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      sb.delete();

      // Random traffic at several write densities
      auto_tx = 1'b1;
      for (int seg = 0; seg < 4; seg++) begin
         for (int c = 0; c < 750; c++) begin
            wr_en   = ($urandom_range(0, 99) < (10 + 27 * seg));
            wr_data = 8'($urandom);
            tick();
         end
      end
      drain();
      chk("random_sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
